// File: rtl/vip_conv2d_filter_scheduler.sv
// Conv2d layer scheduler: broadcasts source pixel triples to NUM_FILTERS filter
// wrappers and drains their results round-robin into one channel-tagged stream.
module vip_conv2d_filter_scheduler #(
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned NUM_FILTERS  = 4,
  parameter int unsigned FIDX_W       = 2,
  parameter int unsigned FRAME_PIXELS = 12544,
  parameter int unsigned CNT_W        = 14
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  input  logic [3*DWIDTH-1:0]           src_data,
  input  logic                          src_valid,
  output logic                          src_ready,
  output logic [3*DWIDTH-1:0]           flt_in_data,
  output logic [NUM_FILTERS-1:0]        flt_in_wrreq,
  input  logic [NUM_FILTERS-1:0]        flt_in_full,
  input  logic [DWIDTH*NUM_FILTERS-1:0] flt_out_data,
  output logic [NUM_FILTERS-1:0]        flt_out_rdreq,
  input  logic [NUM_FILTERS-1:0]        flt_out_empty,
  output logic [DWIDTH-1:0]             dst_data,
  output logic [FIDX_W-1:0]             dst_ch,
  output logic                          dst_valid,
  input  logic                          dst_ready,
  output logic [CNT_W-1:0]              px_count
);

  localparam logic [CNT_W-1:0]  FRAME_END = CNT_W'(FRAME_PIXELS);
  localparam logic [FIDX_W-1:0] CH_LAST   = FIDX_W'(NUM_FILTERS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        feed_cnt;
  logic [FIDX_W-1:0]       ch;
  logic                    feed_en;
  logic                    drain_act;
  logic                    out_free;
  logic                    pop;
  logic                    sel_empty;
  logic [DWIDTH-1:0]       sel_data;
  logic [NUM_FILTERS-1:0]  ch_onehot;

  // Select the output FIFO currently owed a word (strict round-robin, no skipping).
  always_comb begin
    sel_data  = '0;
    sel_empty = 1'b1;
    ch_onehot = '0;
    for (int unsigned f = 0; f < NUM_FILTERS; f++) begin
      if (ch == FIDX_W'(f)) begin
        sel_data     = flt_out_data[f*DWIDTH +: DWIDTH];
        sel_empty    = flt_out_empty[f];
        ch_onehot[f] = 1'b1;
      end
    end
  end

  // Next state plus the handshake strobes; feed is all-or-nothing across filters.
  always_comb begin
    state_next    = state;
    busy          = 1'b0;
    done          = 1'b0;
    feed_en       = 1'b0;
    drain_act     = 1'b0;
    out_free      = ~dst_valid | dst_ready;
    pop           = 1'b0;
    src_ready     = 1'b0;
    flt_in_data   = src_data;
    flt_in_wrreq  = '0;
    flt_out_rdreq = '0;

    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        drain_act = 1'b1;
        feed_en   = src_valid & ~|flt_in_full & (feed_cnt < FRAME_END);
        if (feed_cnt == FRAME_END) state_next = FLUSH;
      end
      FLUSH: begin
        busy      = 1'b1;
        drain_act = 1'b1;
        if ((px_count == FRAME_END) && out_free) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    pop           = drain_act & out_free & ~sel_empty & (px_count != FRAME_END);
    src_ready     = feed_en;
    flt_in_wrreq  = {NUM_FILTERS{feed_en}};
    flt_out_rdreq = pop ? ch_onehot : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Frame counters and the channel pointer; a new frame starts from a clean slate.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      feed_cnt <= '0;
      px_count <= '0;
      ch       <= '0;
    end else if ((state == IDLE) && start) begin
      feed_cnt <= '0;
      px_count <= '0;
      ch       <= '0;
    end else begin
      if (feed_en) feed_cnt <= feed_cnt + CNT_W'(1);
      if (pop) begin
        if (ch == CH_LAST) begin
          ch       <= '0;
          px_count <= px_count + CNT_W'(1);
        end else begin
          ch <= ch + FIDX_W'(1);
        end
      end
    end
  end

  // Output register holds data and channel stable until the consumer takes them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dst_data  <= '0;
      dst_ch    <= '0;
      dst_valid <= 1'b0;
    end else if (pop) begin
      dst_data  <= sel_data;
      dst_ch    <= ch;
      dst_valid <= 1'b1;
    end else if (dst_ready) begin
      dst_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vip_conv2d_filter_scheduler.sv
// Bench for vip_conv2d_filter_scheduler: random source, filter and sink behaviour
// checked each cycle against a counting model of feed, round-robin drain and frame end.
module tb_vip_conv2d_filter_scheduler;

  localparam int unsigned DW = 32;
  localparam int unsigned NF = 2;
  localparam int unsigned FW = 1;
  localparam int unsigned FP = 4;
  localparam int unsigned CW = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              busy;
  logic              done;
  logic [3*DW-1:0]   src_data;
  logic              src_valid;
  logic              src_ready;
  logic [3*DW-1:0]   flt_in_data;
  logic [NF-1:0]     flt_in_wrreq;
  logic [NF-1:0]     flt_in_full;
  logic [DW*NF-1:0]  flt_out_data;
  logic [NF-1:0]     flt_out_rdreq;
  logic [NF-1:0]     flt_out_empty;
  logic [DW-1:0]     dst_data;
  logic [FW-1:0]     dst_ch;
  logic              dst_valid;
  logic              dst_ready;
  logic [CW-1:0]     px_count;

  vip_conv2d_filter_scheduler #(
    .DWIDTH(DW), .NUM_FILTERS(NF), .FIDX_W(FW), .FRAME_PIXELS(FP), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .flt_in_data(flt_in_data), .flt_in_wrreq(flt_in_wrreq), .flt_in_full(flt_in_full),
    .flt_out_data(flt_out_data), .flt_out_rdreq(flt_out_rdreq), .flt_out_empty(flt_out_empty),
    .dst_data(dst_data), .dst_ch(dst_ch), .dst_valid(dst_valid), .dst_ready(dst_ready),
    .px_count(px_count)
  );

  always #5 clock = ~clock;

  int          errors = 0;
  int          checks = 0;

  // Stimulus knobs (percent probabilities)
  int unsigned p_valid, p_full, p_hide, p_ready;
  bit          seq_data;
  int unsigned pix_seq;

  // Reference model: frame bookkeeping by counts, filters as pop pointers into pixq
  bit          frame_open;
  bit          done_now;
  bit          dv_exp;
  int unsigned fed, popped, acc, dut_done_cnt;
  int unsigned fpop [NF];
  logic [31:0] pixq [$];

  function automatic logic [31:0] fres(input logic [31:0] w, input int unsigned f);
    return w + 32'(10 * (f + 1));
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    frame_open = 1'b0;
    done_now   = 1'b0;
    dv_exp     = 1'b0;
    fed        = 0;
    popped     = 0;
    acc        = 0;
    pixq.delete();
    for (int f = 0; f < int'(NF); f++) fpop[f] = 0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_busy"},      busy,          0);
    chk({pfx, "_done"},      done,          0);
    chk({pfx, "_src_ready"}, src_ready,     0);
    chk({pfx, "_wrreq"},     flt_in_wrreq,  0);
    chk({pfx, "_rdreq"},     flt_out_rdreq, 0);
    chk({pfx, "_dst_valid"}, dst_valid,     0);
    chk({pfx, "_dst_data"},  dst_data,      0);
    chk({pfx, "_dst_ch"},    dst_ch,        0);
    chk({pfx, "_px_count"},  px_count,      0);
  endtask

  // One clock: drive at negedge, check at negedge+1, advance the model at posedge.
  task automatic run_cycle(input bit st);
    bit            idle, feed_x, free_x, pop_x, done_x;
    int unsigned   cch, k;
    logic [NF-1:0] rd_x;
    @(negedge clock);
    start     = st;
    src_valid = ($urandom_range(99) < p_valid);
    src_data  = {$urandom, $urandom, (seq_data ? 32'(pix_seq) : $urandom)};
    for (int f = 0; f < int'(NF); f++) begin
      flt_in_full[f]             = ($urandom_range(99) < p_full);
      flt_out_empty[f]           = !(fpop[f] < fed) || ($urandom_range(99) < p_hide);
      flt_out_data[f*DW +: DW]   = (fpop[f] < fed) ? fres(pixq[fpop[f]], f) : 32'hDEAD_BEEF;
    end
    dst_ready = ($urandom_range(99) < p_ready);
    #1;
    idle   = !frame_open && !done_now;
    feed_x = frame_open && (fed < FP) && src_valid && (flt_in_full == '0);
    free_x = !dv_exp || dst_ready;
    cch    = popped % NF;
    pop_x  = frame_open && free_x && (popped < FP * NF) && !flt_out_empty[cch];
    rd_x   = '0;
    if (pop_x) rd_x[cch] = 1'b1;

    chk("src_ready",    src_ready,     feed_x);
    chk("flt_in_wrreq", flt_in_wrreq,  {NF{feed_x}});
    chk("flt_in_data",  flt_in_data,   src_data);
    chk("flt_out_rdreq", flt_out_rdreq, rd_x);
    chk("busy",         busy,          frame_open);
    chk("done",         done,          done_now);
    chk("px_count",     px_count,      popped / NF);
    chk("dst_valid",    dst_valid,     dv_exp);
    if (dv_exp) begin
      k = acc;
      chk("dst_data", dst_data, fres(pixq[k / NF], k % NF));
      chk("dst_ch",   dst_ch,   k % NF);
    end
    if (done === 1'b1) dut_done_cnt++;

    @(posedge clock);
    done_x = frame_open && (popped == FP * NF) && free_x;
    if (feed_x) begin
      pixq.push_back(src_data[31:0]);
      fed++;
      if (seq_data) pix_seq++;
    end
    if (pop_x) begin
      fpop[cch]++;
      popped++;
    end
    if (dv_exp && dst_ready) acc++;
    dv_exp = pop_x ? 1'b1 : (dst_ready ? 1'b0 : dv_exp);
    if (done_x) frame_open = 1'b0;
    done_now = done_x;
    if (st && idle) begin
      frame_open = 1'b1;
      fed        = 0;
      popped     = 0;
      acc        = 0;
      pixq.delete();
      for (int f = 0; f < int'(NF); f++) fpop[f] = 0;
    end
  endtask

  // Full frame: start in IDLE, optional stray starts while busy, expect one done pulse.
  task automatic run_frame(input int unsigned start_prob);
    int unsigned n;
    int unsigned done_before;
    done_before = dut_done_cnt;
    n = 0;
    run_cycle(1'b1);
    while (!done_now && n < 500) begin
      run_cycle(frame_open && ($urandom_range(99) < start_prob));
      n++;
    end
    chk("frame_completes", done_now, 1);
    run_cycle(1'b0);
    run_cycle(1'b0);
    chk("done_pulse_count", dut_done_cnt - done_before, 1);
    chk("px_count_final",   px_count, FP);
  endtask

  initial begin
    int unsigned n;
    int unsigned done_before;
    reset = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = '0;
    flt_in_full = '0; flt_out_empty = '1; flt_out_data = '0; dst_ready = 1'b0;
    seq_data = 1'b0; pix_seq = 0; dut_done_cnt = 0;
    p_valid = 50; p_full = 0; p_hide = 0; p_ready = 100;
    model_reset();

    #2 reset = 1'b0;
    #1;
    chk_all_zero("por");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) run_cycle(1'b0);

    // Directed frame: pixel p gives f0=10+p, f1=20+p, everything always ready
    seq_data = 1'b1; pix_seq = 0;
    p_valid = 100; p_full = 0; p_hide = 0; p_ready = 100;
    run_frame(0);

    // Randomised frames with input-FIFO full, output gaps, sink backpressure, stray starts
    seq_data = 1'b0;
    p_valid = 70; p_full = 20; p_hide = 25; p_ready = 60;
    run_frame(15);
    p_valid = 40; p_full = 40; p_hide = 50; p_ready = 30;
    run_frame(15);
    p_valid = 90; p_full = 5;  p_hide = 5;  p_ready = 90;
    run_frame(5);

    // Abort mid-frame once two pixels are drained
    p_valid = 80; p_full = 10; p_hide = 10; p_ready = 80;
    run_cycle(1'b1);
    n = 0;
    while (popped < 2 * NF && n < 500) begin
      run_cycle(1'b0);
      n++;
    end
    chk("abort_reached_px2", popped, 2 * NF);
    @(negedge clock);
    #1;
    chk("abort_px_count_before", px_count, 2);
    #1 reset = 1'b0;
    #1;
    chk_all_zero("abort");
    start = 1'b0; src_valid = 1'b0; dst_ready = 1'b0;
    model_reset();
    done_before = dut_done_cnt;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (4) run_cycle(1'b0);
    chk("abort_no_done", dut_done_cnt - done_before, 0);

    // Clean frame after the abort
    seq_data = 1'b1; pix_seq = 100;
    p_valid = 85; p_full = 15; p_hide = 15; p_ready = 75;
    run_frame(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
